// File: rtl/rst_pkg.sv
// Shared constants, types and helper functions for the rotating-table decipher.
package rst_pkg;

  localparam int KEY_LEN   = 12;
  localparam int TABLE_DIM = 6;

  localparam logic [7:0] CH_UPPER_A = 8'h41;
  localparam logic [7:0] CH_UPPER_Z = 8'h5A;
  localparam logic [7:0] CH_LOWER_A = 8'h61;
  localparam logic [7:0] CH_LOWER_Z = 8'h7A;
  localparam logic [7:0] CH_DIGIT_0 = 8'h30;
  localparam logic [7:0] CH_DIGIT_9 = 8'h39;

  typedef logic [KEY_LEN-1:0][7:0]   key_t;
  typedef logic [TABLE_DIM-1:0][7:0] line_t;

  typedef enum logic {
    NO_KEY = 1'b0,
    RUN    = 1'b1
  } state_t;

  // A key character is a letter of either case or a decimal digit.
  function automatic logic is_key_char(input logic [7:0] ch);
    return ((ch >= CH_UPPER_A) && (ch <= CH_UPPER_Z)) ||
           ((ch >= CH_LOWER_A) && (ch <= CH_LOWER_Z)) ||
           ((ch >= CH_DIGIT_0) && (ch <= CH_DIGIT_9));
  endfunction

  // Table position 0..25 maps to a letter, 26..35 maps to '0'..'9'.
  function automatic logic [7:0] idx_to_char(input logic [5:0] n, input logic upper);
    logic [7:0] n8;
    n8 = {2'b00, n};
    if (n < 6'd26) begin
      return (upper ? CH_UPPER_A : CH_LOWER_A) + n8;
    end
    return CH_DIGIT_0 + (n8 - 8'd26);
  endfunction

endpackage

// File: rtl/rst_lookup6.sv
// Combinational search of one character across a 6-entry table line.
// Key characters are distinct, so at most one entry can match.
module rst_lookup6
  import rst_pkg::*;
(
  input  logic [7:0] char_i,
  input  line_t      line_i,
  output logic       hit_o,
  output logic [2:0] idx_o
);

  // Scan from the top so the lowest matching index is reported.
  always_comb begin
    hit_o = 1'b0;
    idx_o = 3'd0;
    for (int i = TABLE_DIM - 1; i >= 0; i--) begin
      if (line_i[i] == char_i) begin
        hit_o = 1'b1;
        idx_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/rst_decipher.sv
// Rotating 6x6 table decipher: turns {row,col} ciphertext symbols back into
// plaintext characters with one cycle of latency.
// Optional build macro RST_DECIPHER_ERR_CNT_EN adds the saturating err_cnt output.
module rst_decipher
  import rst_pkg::*;
#(
  parameter bit UPPER_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_install,
  input  logic [95:0] key,
  input  logic        ctxt_valid,
  input  logic [15:0] ctxt_str,
  output logic [7:0]  ptxt_char,
  output logic        ptxt_ready,
  output logic        key_installed,
  output logic        err_invalid_key,
  output logic        err_key_not_installed,
  output logic        err_invalid_ctxt
`ifdef RST_DECIPHER_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  key_t       keyVec;
  state_t     state_q;
  line_t      rowTab_q;
  line_t      colTab_q;
  line_t      rowTab_d;
  line_t      colTab_d;
  line_t      rowInit;
  line_t      colInit;
  logic       keyOk;
  logic       rowHit;
  logic       colHit;
  logic [2:0] rowIdx;
  logic [2:0] colIdx;
  logic [5:0] symIdx;
  logic [7:0] ptxtChar_q;
  logic       ptxtReady_q;
  logic       keyInstalled_q;
  logic       errInvalidKey_q;
  logic       errKeyNotInst_q;
  logic       errInvalidCtxt_q;

  assign keyVec = key_t'(key);

  // Key is usable only if every character is legal and no two are equal.
  always_comb begin
    keyOk = 1'b1;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (!is_key_char(keyVec[i])) begin
        keyOk = 1'b0;
      end
      for (int j = i + 1; j < KEY_LEN; j++) begin
        if (keyVec[i] == keyVec[j]) begin
          keyOk = 1'b0;
        end
      end
    end
  end

  // Interleave the key into row and column headers, then form the rotated lines.
  always_comb begin
    rowInit[0] = keyVec[11];
    rowInit[1] = keyVec[1];
    rowInit[2] = keyVec[9];
    rowInit[3] = keyVec[3];
    rowInit[4] = keyVec[7];
    rowInit[5] = keyVec[5];
    colInit[0] = keyVec[10];
    colInit[1] = keyVec[0];
    colInit[2] = keyVec[8];
    colInit[3] = keyVec[2];
    colInit[4] = keyVec[6];
    colInit[5] = keyVec[4];
    rowTab_d   = {rowTab_q[4:0], rowTab_q[5]};
    colTab_d   = {colTab_q[4:0], colTab_q[5]};
  end

  rst_lookup6 u_rowLookup (
    .char_i (ctxt_str[15:8]),
    .line_i (rowTab_q),
    .hit_o  (rowHit),
    .idx_o  (rowIdx)
  );

  rst_lookup6 u_colLookup (
    .char_i (ctxt_str[7:0]),
    .line_i (colTab_q),
    .hit_o  (colHit),
    .idx_o  (colIdx)
  );

  assign symIdx = ({3'b000, rowIdx} * 6'd6) + {3'b000, colIdx};

  // Key/run state machine; decode results and error pulses are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= NO_KEY;
      rowTab_q         <= '0;
      colTab_q         <= '0;
      ptxtChar_q       <= 8'h00;
      ptxtReady_q      <= 1'b0;
      keyInstalled_q   <= 1'b0;
      errInvalidKey_q  <= 1'b0;
      errKeyNotInst_q  <= 1'b0;
      errInvalidCtxt_q <= 1'b0;
    end else begin
      ptxtChar_q       <= 8'h00;
      ptxtReady_q      <= 1'b0;
      errKeyNotInst_q  <= 1'b0;
      errInvalidCtxt_q <= 1'b0;
      if (key_install) begin
        if (keyOk) begin
          state_q         <= RUN;
          rowTab_q        <= rowInit;
          colTab_q        <= colInit;
          keyInstalled_q  <= 1'b1;
          errInvalidKey_q <= 1'b0;
        end else begin
          state_q         <= NO_KEY;
          keyInstalled_q  <= 1'b0;
          errInvalidKey_q <= 1'b1;
        end
      end else if (ctxt_valid) begin
        if (state_q == NO_KEY) begin
          errKeyNotInst_q <= 1'b1;
        end else if (rowHit && colHit) begin
          ptxtChar_q  <= idx_to_char(symIdx, UPPER_OUT);
          ptxtReady_q <= 1'b1;
          rowTab_q    <= rowTab_d;
          colTab_q    <= colTab_d;
        end else begin
          errInvalidCtxt_q <= 1'b1;
        end
      end
    end
  end

  assign ptxt_char             = ptxtChar_q;
  assign ptxt_ready            = ptxtReady_q;
  assign key_installed         = keyInstalled_q;
  assign err_invalid_key       = errInvalidKey_q;
  assign err_key_not_installed = errKeyNotInst_q;
  assign err_invalid_ctxt      = errInvalidCtxt_q;

`ifdef RST_DECIPHER_ERR_CNT_EN
  logic       errEvent;
  logic [7:0] errCnt_q;

  assign errEvent = !key_install && ctxt_valid &&
                    ((state_q == NO_KEY) || !(rowHit && colHit));

  // Saturating error tally, bumped on the same edge that raises an error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      errCnt_q <= 8'h00;
    end else if (key_install && keyOk) begin
      errCnt_q <= 8'h00;
    end else if (errEvent && (errCnt_q != 8'hFF)) begin
      errCnt_q <= errCnt_q + 8'd1;
    end
  end

  assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_rst_decipher.sv
// Randomized self-checking bench for rst_decipher against a rotation-offset model.
// Builds with or without RST_DECIPHER_ERR_CNT_EN.
module tb_rst_decipher;

  logic        clk = 1'b0;
  logic        rst;
  logic        keyInstall;
  logic [95:0] keyIn;
  logic        ctxtValid;
  logic [15:0] ctxtStr;

  logic [7:0]  ptxtCharUp, ptxtCharLo;
  logic        ptxtReadyUp, ptxtReadyLo;
  logic        keyInstUp, keyInstLo;
  logic        errKeyUp, errKeyLo;
  logic        errNkUp, errNkLo;
  logic        errCtxtUp, errCtxtLo;
`ifdef RST_DECIPHER_ERR_CNT_EN
  logic [7:0]  errCntUp, errCntLo;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: table kept in initial orientation plus a rotation count.
  logic [7:0] mRows[6];
  logic [7:0] mCols[6];
  int         mRot = 0;
  bit         mLoaded = 0;
  bit         mErrKey = 0;
  int         mErrCnt = 0;
  bit         eReady = 0;
  int         eIdx = 0;
  bit         eNk = 0;
  bit         eCtxt = 0;
  logic [95:0] curKey = 96'h0;

  always #5 clk = ~clk;

  rst_decipher #(.UPPER_OUT(1'b1)) dutUp (
    .clk                   (clk),
    .rst                   (rst),
    .key_install           (keyInstall),
    .key                   (keyIn),
    .ctxt_valid            (ctxtValid),
    .ctxt_str              (ctxtStr),
    .ptxt_char             (ptxtCharUp),
    .ptxt_ready            (ptxtReadyUp),
    .key_installed         (keyInstUp),
    .err_invalid_key       (errKeyUp),
    .err_key_not_installed (errNkUp),
    .err_invalid_ctxt      (errCtxtUp)
`ifdef RST_DECIPHER_ERR_CNT_EN
    ,
    .err_cnt               (errCntUp)
`endif
  );

  rst_decipher #(.UPPER_OUT(1'b0)) dutLo (
    .clk                   (clk),
    .rst                   (rst),
    .key_install           (keyInstall),
    .key                   (keyIn),
    .ctxt_valid            (ctxtValid),
    .ctxt_str              (ctxtStr),
    .ptxt_char             (ptxtCharLo),
    .ptxt_ready            (ptxtReadyLo),
    .key_installed         (keyInstLo),
    .err_invalid_key       (errKeyLo),
    .err_key_not_installed (errNkLo),
    .err_invalid_ctxt      (errCtxtLo)
`ifdef RST_DECIPHER_ERR_CNT_EN
    ,
    .err_cnt               (errCntLo)
`endif
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic bit isKeyChar(input logic [7:0] ch);
    return (ch >= "A" && ch <= "Z") || (ch >= "a" && ch <= "z") || (ch >= "0" && ch <= "9");
  endfunction

  function automatic bit keyIsValid(input logic [95:0] k);
    for (int i = 0; i < 12; i++) begin
      if (!isKeyChar(k[i*8 +: 8])) return 1'b0;
      for (int j = 0; j < i; j++) begin
        if (k[i*8 +: 8] == k[j*8 +: 8]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] charFor(input int n, input bit upper);
    if (n < 26) return 8'((upper ? 65 : 97) + n);
    return 8'(48 + n - 26);
  endfunction

  // Header character currently sitting at table position p.
  function automatic logic [7:0] rowAt(input int p);
    return mRows[(p - mRot + 6) % 6];
  endfunction

  function automatic logic [7:0] colAt(input int p);
    return mCols[(p - mRot + 6) % 6];
  endfunction

  // Encrypt plaintext index n with the current table orientation.
  function automatic logic [15:0] symFor(input int n);
    return {rowAt(n / 6), colAt(n % 6)};
  endfunction

  function automatic int modelDecode(input logic [15:0] s);
    int r = -1;
    int c = -1;
    for (int p = 0; p < 6; p++) begin
      if (rowAt(p) == s[15:8]) r = p;
      if (colAt(p) == s[7:0])  c = p;
    end
    if (r < 0 || c < 0) return -1;
    return 6 * r + c;
  endfunction

  // Twelve distinct legal characters, or a deliberately broken key.
  function automatic logic [95:0] randomKey(input bit makeValid);
    logic [7:0] pool[62];
    logic [7:0] tmp;
    logic [95:0] k;
    int j;
    int pos;
    for (int i = 0; i < 26; i++) begin
      pool[i]      = 8'(65 + i);
      pool[26 + i] = 8'(97 + i);
    end
    for (int i = 0; i < 10; i++) pool[52 + i] = 8'(48 + i);
    for (int i = 61; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = pool[i]; pool[i] = pool[j]; pool[j] = tmp;
    end
    for (int i = 0; i < 12; i++) k[i*8 +: 8] = pool[i];
    if (!makeValid) begin
      pos = int'($urandom_range(0, 11));
      if ($urandom_range(0, 1) == 0) k[pos*8 +: 8] = 8'h3F;
      else k[pos*8 +: 8] = k[((pos + 1) % 12)*8 +: 8];
    end
    return k;
  endfunction

  // Advance the model by one edge using the inputs about to be applied.
  task automatic modelStep(input logic inst, input logic [95:0] k, input logic v, input logic [15:0] s, input logic r);
    int n;
    int rowSel[6] = '{11, 1, 9, 3, 7, 5};
    int colSel[6] = '{10, 0, 8, 2, 6, 4};
    eReady = 0; eIdx = 0; eNk = 0; eCtxt = 0;
    if (r) begin
      mLoaded = 0; mErrKey = 0; mErrCnt = 0;
    end else if (inst) begin
      if (keyIsValid(k)) begin
        for (int i = 0; i < 6; i++) begin
          mRows[i] = k[rowSel[i]*8 +: 8];
          mCols[i] = k[colSel[i]*8 +: 8];
        end
        mRot = 0; mLoaded = 1; mErrKey = 0; mErrCnt = 0;
      end else begin
        mLoaded = 0; mErrKey = 1;
      end
    end else if (v) begin
      if (!mLoaded) begin
        eNk = 1;
        if (mErrCnt < 255) mErrCnt++;
      end else begin
        n = modelDecode(s);
        if (n >= 0) begin
          eReady = 1; eIdx = n; mRot = (mRot + 1) % 6;
        end else begin
          eCtxt = 1;
          if (mErrCnt < 255) mErrCnt++;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, step the model, then compare every output.
  task automatic applyStimulus(input logic inst, input logic [95:0] k, input logic v, input logic [15:0] s, input logic r);
    rst = r; keyInstall = inst; keyIn = k; ctxtValid = v; ctxtStr = s;
    modelStep(inst, k, v, s, r);
    @(posedge clk);
    #1;
    checkOutput("ready_up",  32'(ptxtReadyUp), 32'(eReady));
    checkOutput("char_up",   32'(ptxtCharUp),  32'(eReady ? charFor(eIdx, 1'b1) : 8'h00));
    checkOutput("ready_lo",  32'(ptxtReadyLo), 32'(eReady));
    checkOutput("char_lo",   32'(ptxtCharLo),  32'(eReady ? charFor(eIdx, 1'b0) : 8'h00));
    checkOutput("keyinst",   32'(keyInstUp),   32'(mLoaded));
    checkOutput("keyinst_lo",32'(keyInstLo),   32'(mLoaded));
    checkOutput("errkey",    32'(errKeyUp),    32'(mErrKey));
    checkOutput("errkey_lo", 32'(errKeyLo),    32'(mErrKey));
    checkOutput("errnk",     32'(errNkUp),     32'(eNk));
    checkOutput("errnk_lo",  32'(errNkLo),     32'(eNk));
    checkOutput("errctxt",   32'(errCtxtUp),   32'(eCtxt));
    checkOutput("errctxt_lo",32'(errCtxtLo),   32'(eCtxt));
`ifdef RST_DECIPHER_ERR_CNT_EN
    checkOutput("errcnt",    32'(errCntUp),    32'(mErrCnt));
    checkOutput("errcnt_lo", 32'(errCntLo),    32'(mErrCnt));
`endif
    rst = 1'b0; keyInstall = 1'b0; ctxtValid = 1'b0;
  endtask

  task automatic install(input logic [95:0] k);
    curKey = k;
    applyStimulus(1'b1, k, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic sendSym(input logic [15:0] s);
    applyStimulus(1'b0, curKey, 1'b1, s, 1'b0);
  endtask

  initial begin
    logic [15:0] helloSym[5] = '{"KL", "GJ", "GJ", "ED", "EF"};
    logic [7:0]  helloExp[5] = '{"H", "E", "L", "L", "O"};
    int sel;

    rst = 1'b1; keyInstall = 1'b0; keyIn = '0; ctxtValid = 1'b0; ctxtStr = '0;
    $display("[TB] reset");
    applyStimulus(1'b0, 96'h0, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 96'h0, 1'b0, 16'h0000, 1'b1);
    checkOutput("rst_keyinst", 32'(keyInstUp), 32'd0);

    $display("[TB] hello");
    install("ABCDEFGHIJKL");
    checkOutput("t1_keyinst", 32'(keyInstUp), 32'd1);
    for (int i = 0; i < 5; i++) begin
      sendSym(helloSym[i]);
      checkOutput("hello_rdy", 32'(ptxtReadyUp), 32'd1);
      checkOutput("hello", 32'(ptxtCharUp), 32'(helloExp[i]));
    end

    $display("[TB] full alphabet");
    install("abcdefghijkl");
    for (int n = 0; n < 36; n++) begin
      sendSym(symFor(n));
      checkOutput("seq_up", 32'(ptxtCharUp), 32'(n < 26 ? 8'(65 + n) : 8'(48 + n - 26)));
      checkOutput("seq_lo", 32'(ptxtCharLo), 32'(n < 26 ? 8'(97 + n) : 8'(48 + n - 26)));
    end

    $display("[TB] invalid keys");
    install("ABC?EFGHIJKL");
    checkOutput("badkey_err", 32'(errKeyUp), 32'd1);
    checkOutput("badkey_inst", 32'(keyInstUp), 32'd0);
    install("ABCDEFGHDJKL");
    checkOutput("dupkey_err", 32'(errKeyUp), 32'd1);
    checkOutput("dupkey_inst", 32'(keyInstUp), 32'd0);
    sendSym("KL");
    checkOutput("nokey_pulse", 32'(errNkUp), 32'd1);
    checkOutput("nokey_rdy", 32'(ptxtReadyUp), 32'd0);

    $display("[TB] miss does not rotate");
    install("ABCDEFGHIJKL");
    sendSym("KL");
    checkOutput("t4_h", 32'(ptxtCharUp), 32'("H"));
    sendSym("ZZ");
    checkOutput("t4_miss", 32'(errCtxtUp), 32'd1);
    checkOutput("t4_miss_char", 32'(ptxtCharUp), 32'd0);
    sendSym("GJ");
    checkOutput("t4_e", 32'(ptxtCharUp), 32'("E"));

    $display("[TB] wrap and install collision");
    install("ABCDEFGHIJKL");
    for (int i = 0; i < 6; i++) sendSym(symFor(int'($urandom_range(0, 35))));
    sendSym("KL");
    checkOutput("wrap_h", 32'(ptxtCharUp), 32'("H"));
    applyStimulus(1'b1, curKey, 1'b1, "KL", 1'b0);
    checkOutput("drop_rdy", 32'(ptxtReadyUp), 32'd0);
    checkOutput("drop_err", 32'(errCtxtUp | errNkUp), 32'd0);
    sendSym("KL");
    checkOutput("drop_h", 32'(ptxtCharUp), 32'("H"));

    $display("[TB] reset mid-stream");
    sendSym("GJ");
    applyStimulus(1'b0, curKey, 1'b1, "GJ", 1'b1);
    checkOutput("rst_rdy", 32'(ptxtReadyUp), 32'd0);
    checkOutput("rst_inst", 32'(keyInstUp), 32'd0);
    sendSym("KL");
    checkOutput("rst_nk", 32'(errNkUp), 32'd1);
    for (int i = 0; i < 300; i++) sendSym("ZZ");
`ifdef RST_DECIPHER_ERR_CNT_EN
    checkOutput("errcnt_sat", 32'(errCntUp), 32'd255);
`endif

    $display("[TB] random traffic");
    install(randomKey(1'b1));
    for (int t = 0; t < 400; t++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 3) begin
        applyStimulus(1'b0, curKey, $urandom_range(0, 1) == 1, 16'($urandom), 1'b1);
      end else if (sel < 9) begin
        curKey = randomKey($urandom_range(0, 3) != 0);
        applyStimulus(1'b1, curKey, $urandom_range(0, 1) == 1, symFor(int'($urandom_range(0, 35))), 1'b0);
      end else if (sel < 70) begin
        sendSym(symFor(int'($urandom_range(0, 35))));
      end else if (sel < 85) begin
        sendSym(16'($urandom));
      end else begin
        applyStimulus(1'b0, curKey, 1'b0, 16'($urandom), 1'b0);
      end
    end
    applyStimulus(1'b0, curKey, 1'b0, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_decipher.md
Name: rst_decipher

Overview:
Decryption counterpart of rst_cipher. Accepts 2-character ciphertext symbols {row_char, col_char}, looks them up in the same key-derived 6x6 rotating table, and emits the recovered plaintext character one cycle later. The table rotates after every successful decode, so it stays in lock-step with the encryptor when both use the same key and the same symbol stream.

Parameters:
UPPER_OUT, 1, 1: letters are output as 'A'..'Z'; 0: letters are output as 'a'..'z'. The ciphertext carries no case information.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
key_install  in  1  single-cycle strobe; samples key and (re)initialises the table
key  in  96  [11:0][7:0] key string; key[11] is the leftmost character
ctxt_valid  in  1  ctxt_str is valid this cycle
ctxt_str  in  16  [15:8] row character, [7:0] column character
ptxt_char  out  8  recovered plaintext character
ptxt_ready  out  1  ptxt_char valid (single-cycle pulse per decode)
key_installed  out  1  a valid key is loaded
err_invalid_key  out  1  last key_install was rejected (sticky)
err_key_not_installed  out  1  pulse: ctxt_valid arrived with no key loaded
err_invalid_ctxt  out  1  pulse: a ctxt character was not found in the table

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst).
- Reset (rst=1 at a clk edge): FSM goes to NO_KEY, the table is cleared to 8'h00, and all outputs go to 0. Reset mid-stream discards any in-flight decode; next cycle ptxt_ready=0.
- Valid key character: 'A'-'Z', 'a'-'z', '0'-'9'. All 12 characters must be distinct; comparison is case-sensitive.
- key_install with a valid key:
  - rows[0..5] = key[11], key[1], key[9], key[3], key[7], key[5]
  - cols[0..5] = key[10], key[0], key[8], key[2], key[6], key[4]
  - key_installed=1 and err_invalid_key=0 from the next cycle; FSM goes to RUN.
- key_install with an invalid key: err_invalid_key=1 and key_installed=0; FSM goes to NO_KEY; the table is unchanged.
- Re-installing a key in RUN resets the rotation to the initial orientation.
- FSM states: NO_KEY and RUN only. Transitions occur solely via key_install and rst.
- Decode is evaluated in the cycle ctxt_valid=1 and the FSM is in RUN:
  - r = index with rows[r]==ctxt_str[15:8]; c = index with cols[c]==ctxt_str[7:0].
  - Both hits: n = 6*r + c (range 0..35). Next cycle ptxt_char = letter(n) for n 0..25, or '0'+(n-26) for n 26..35, and ptxt_ready=1.
  - Table rotates on the same edge: rows[0] <= rows[5], rows[i] <= rows[i-1]; cols rotate identically.
- Miss on either character: next cycle err_invalid_ctxt=1, ptxt_ready=0, ptxt_char=8'h00, and the table does NOT rotate.
- ctxt_valid in NO_KEY: next cycle err_key_not_installed=1, ptxt_ready=0, no rotation.
- key_install and ctxt_valid in the same cycle: key_install wins; the symbol is dropped silently (no output, no error).
- ctxt_valid=0: ptxt_ready=0 and ptxt_char=8'h00 the next cycle.
- Latency is exactly 1 cycle. One symbol may be accepted per cycle with no stalls (no back-pressure).
- Rotation wraps naturally: after 6 successful decodes the table returns to its initial orientation.

Optional Feature:
RST_DECIPHER_ERR_CNT_EN
- Defined: adds output err_cnt [7:0].
  - Saturating count of err_invalid_ctxt and err_key_not_installed pulses; holds at 255.
  - Cleared by rst and by a successful key_install.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package rst_pkg holds:
  - constants KEY_LEN=12, TABLE_DIM=6, and the ASCII bounds for 'A', 'Z', 'a', 'z', '0', '9'
  - typedefs key_t ([11:0][7:0]) and line_t ([5:0][7:0])
  - functions is_key_char() and idx_to_char(n, upper)
- One sub-module, rst_lookup6: combinational 6-entry match of an 8-bit character against a line_t, returning hit and a 3-bit index. It is instantiated twice, once for rows and once for columns.

Test Plan:
1. Key "ABCDEFGHIJKL" installed; ctxt KL, GJ, GJ, ED, EF on consecutive cycles -> ptxt "HELLO"; ptxt_ready=1 each cycle, one cycle after each symbol.
2. Key "abcdefghijkl"; a reference model drives 36 symbols encrypting A..Z then 0..9 -> outputs 'A'..'Z','0'..'9' in order. Repeat with UPPER_OUT=0 -> 'a'..'z'.
3. Key "ABC?EFGHIJKL" -> err_invalid_key=1, key_installed=0. Key "ABCDEFGHDJKL" -> same. Then ctxt "KL" -> err_key_not_installed pulse, ptxt_ready=0.
4. Key "ABCDEFGHIJKL"; ctxt "KL" -> 'H'; ctxt "ZZ" -> err_invalid_ctxt=1, no rotation; ctxt "GJ" -> 'E', proving no rotation occurred.
5. Wrap: six valid decodes, then ctxt "KL" -> 'H'. key_install together with ctxt_valid -> symbol dropped and no error; next ctxt "KL" -> 'H'.
6. rst asserted between two valid symbols -> outputs 0, key_installed=0; the following ctxt -> err_key_not_installed. With RST_DECIPHER_ERR_CNT_EN, 300 bad symbols -> err_cnt=255.
